// File: rtl/mem_dump_reader.sv
// Host-side reader for the processor memory-inspection port: walks an address
// range, streams each word over valid/ready with its address and keeps a checksum.
module mem_dump_reader #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int READ_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W-1:0] count_i,
  output logic [ADDR_W-1:0] mem_sel_o,
  input  logic [DATA_W-1:0] mem_out_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              aborted_o,
  output logic [DATA_W-1:0] checksum_o
);

  typedef enum logic [1:0] {IDLE, FETCH, PRESENT, DONE} state_e;

  localparam logic [3:0] LastWait = 4'(READ_LAT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] memSel_q, memSel_d;
  logic [ADDR_W-1:0] remain_q, remain_d;
  logic [ADDR_W-1:0] outAddr_q, outAddr_d;
  logic [DATA_W-1:0] outData_q, outData_d;
  logic [DATA_W-1:0] checksum_q, checksum_d;
  logic              outValid_q, outValid_d;
  logic              aborted_q, aborted_d;
  logic [3:0]        waitCnt_q, waitCnt_d;
  logic              handshake;

  assign handshake = outValid_q & out_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      memSel_q   <= '0;
      remain_q   <= '0;
      outAddr_q  <= '0;
      outData_q  <= '0;
      checksum_q <= '0;
      outValid_q <= 1'b0;
      aborted_q  <= 1'b0;
      waitCnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      memSel_q   <= memSel_d;
      remain_q   <= remain_d;
      outAddr_q  <= outAddr_d;
      outData_q  <= outData_d;
      checksum_q <= checksum_d;
      outValid_q <= outValid_d;
      aborted_q  <= aborted_d;
      waitCnt_q  <= waitCnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    memSel_d   = memSel_q;
    remain_d   = remain_q;
    outAddr_d  = outAddr_q;
    outData_d  = outData_q;
    checksum_d = checksum_q;
    outValid_d = outValid_q;
    aborted_d  = aborted_q;
    waitCnt_d  = waitCnt_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          remain_d   = count_i;
          checksum_d = '0;
          aborted_d  = 1'b0;
          if (count_i == '0) begin
            state_d = DONE;
          end else begin
            memSel_d  = base_addr_i;
            waitCnt_d = '0;
            state_d   = FETCH;
          end
        end
      end
      FETCH: begin
        if (abort_i) begin
          aborted_d = 1'b1;
          state_d   = DONE;
        end else if (waitCnt_q == LastWait) begin
          outData_d  = mem_out_i;
          outAddr_d  = memSel_q;
          outValid_d = 1'b1;
          state_d    = PRESENT;
        end else begin
          waitCnt_d = waitCnt_q + 4'd1;
        end
      end
      PRESENT: begin
        // A handshake coinciding with abort completes first; abort then only
        // counts as an abort if words were still left afterwards.
        if (handshake) begin
          checksum_d = checksum_q + outData_q;
          remain_d   = remain_q - ADDR_W'(1);
          outValid_d = 1'b0;
          if (remain_q == ADDR_W'(1)) begin
            state_d = DONE;
          end else if (abort_i) begin
            aborted_d = 1'b1;
            state_d   = DONE;
          end else begin
            memSel_d  = memSel_q + ADDR_W'(1);
            waitCnt_d = '0;
            state_d   = FETCH;
          end
        end else if (abort_i) begin
          outValid_d = 1'b0;
          aborted_d  = 1'b1;
          state_d    = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mem_sel_o   = memSel_q;
  assign out_valid_o = outValid_q;
  assign out_data_o  = outData_q;
  assign out_addr_o  = outAddr_q;
  assign busy_o      = (state_q == FETCH) || (state_q == PRESENT);
  assign done_o      = (state_q == DONE);
  assign aborted_o   = aborted_q;
  assign checksum_o  = checksum_q;

endmodule
